// File: rtl/graphics_control.sv
// graphics_control
// ----------------
// Control FSM that sits directly in front of the 8x8 sprite datapath. It takes
// one draw request at a time and walks the datapath through a load cycle plus
// 64 pixel-enable cycles. When asked, and when an earlier sprite exists, it
// first repaints that earlier sprite in the background colour.
//
// Request handshake: a request is taken on a rising clock edge where go=1 and
// ready=1. ready is high only in IDLE. While ready=0, go is ignored and is not
// remembered. done pulses for one cycle when the sprite is complete, and ready
// comes back in the following cycle.
//
// Ports:
//   clock, resetn       system clock (rising edge); asynchronous active-low reset
//   go                  request strobe, sampled only while ready=1
//   x_req, y_req        sprite top-left corner
//   colour_req          sprite colour
//   flash_req           draw the sprite in white instead of colour_req
//   erase_en            erase the previously drawn sprite first
//   ready               request may be issued (IDLE)
//   done                one-cycle completion pulse
//   load                datapath: latch x_dp/y_dp/colour_dp, clear pixel counter
//   enable              datapath: pixel counter enable
//   flash               datapath: force colour white
//   plot                VGA adapter: write the current datapath pixel
//   x_dp, y_dp          datapath coordinate inputs (held between loads)
//   colour_dp           datapath colour input (held between loads)
//   state_dbg           current FSM state, for observation only
module graphics_control #(
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         PIXELS    = 64
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       go,
    input  logic [7:0] x_req,
    input  logic [7:0] y_req,
    input  logic [2:0] colour_req,
    input  logic       flash_req,
    input  logic       erase_en,
    output logic       ready,
    output logic       done,
    output logic       load,
    output logic       enable,
    output logic       flash,
    output logic       plot,
    output logic [7:0] x_dp,
    output logic [7:0] y_dp,
    output logic [2:0] colour_dp,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_E = 3'd1;
    localparam logic [2:0] ERASE  = 3'd2;
    localparam logic [2:0] LOAD_D = 3'd3;
    localparam logic [2:0] DRAW   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    // The pixel counter is 6 bits wide, so only a 64-pixel sprite is meaningful.
    localparam logic [5:0] LAST_PIX = 6'(PIXELS - 1);

    logic [2:0] state;
    logic [2:0] state_next;

    logic [7:0] x_lat;
    logic [7:0] y_lat;
    logic [2:0] colour_lat;
    logic       flash_lat;

    logic [7:0] prev_x;
    logic [7:0] prev_y;
    logic       prev_valid;

    logic [5:0] pix_cnt;
    logic       last_pix;
    logic       start_erase;

    assign last_pix    = (pix_cnt == LAST_PIX);
    // Erasing is only possible once a sprite has actually been drawn.
    assign start_erase = erase_en && prev_valid;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = start_erase ? LOAD_E : LOAD_D;
            LOAD_E:  state_next = ERASE;
            ERASE:   if (last_pix) state_next = LOAD_D;
            LOAD_D:  state_next = DRAW;
            DRAW:    if (last_pix) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            x_lat      <= '0;
            y_lat      <= '0;
            colour_lat <= '0;
            flash_lat  <= 1'b0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
            pix_cnt    <= '0;
            x_dp       <= '0;
            y_dp       <= '0;
            colour_dp  <= '0;
        end else begin
            state <= state_next;

            // Datapath inputs are loaded on the edge that enters a load state,
            // so they are already stable while load=1 and hold afterwards.
            case (state)
                IDLE: begin
                    if (go) begin
                        x_lat      <= x_req;
                        y_lat      <= y_req;
                        colour_lat <= colour_req;
                        flash_lat  <= flash_req;
                        if (start_erase) begin
                            x_dp      <= prev_x;
                            y_dp      <= prev_y;
                            colour_dp <= BG_COLOUR;
                        end else begin
                            x_dp      <= x_req;
                            y_dp      <= y_req;
                            colour_dp <= colour_req;
                        end
                    end
                end
                ERASE: begin
                    if (last_pix) begin
                        x_dp      <= x_lat;
                        y_dp      <= y_lat;
                        colour_dp <= colour_lat;
                    end
                end
                DONE: begin
                    prev_x     <= x_lat;
                    prev_y     <= y_lat;
                    prev_valid <= 1'b1;
                end
                default: ;
            endcase

            if (state == LOAD_E || state == LOAD_D) begin
                pix_cnt <= '0;
            end else if (state == ERASE || state == DRAW) begin
                pix_cnt <= pix_cnt + 6'd1;
            end
        end
    end

    // Control outputs are decoded from the state alone so an asynchronous
    // reset drops them immediately.
    always_comb begin
        ready  = (state == IDLE);
        done   = (state == DONE);
        load   = (state == LOAD_E) || (state == LOAD_D);
        enable = (state == LOAD_E) || (state == ERASE) ||
                 (state == LOAD_D) || (state == DRAW);
        plot   = (state == ERASE) || (state == DRAW);
        flash  = ((state == LOAD_D) || (state == DRAW)) && flash_lat;
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_graphics_control.sv
module tb_graphics_control;

    logic       clock;
    logic       resetn;
    logic       go;
    logic [7:0] x_req;
    logic [7:0] y_req;
    logic [2:0] colour_req;
    logic       flash_req;
    logic       erase_en;
    logic       ready;
    logic       done;
    logic       load;
    logic       enable;
    logic       flash;
    logic       plot;
    logic [7:0] x_dp;
    logic [7:0] y_dp;
    logic [2:0] colour_dp;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;

    graphics_control dut (
        .clock      (clock),
        .resetn     (resetn),
        .go         (go),
        .x_req      (x_req),
        .y_req      (y_req),
        .colour_req (colour_req),
        .flash_req  (flash_req),
        .erase_en   (erase_en),
        .ready      (ready),
        .done       (done),
        .load       (load),
        .enable     (enable),
        .flash      (flash),
        .plot       (plot),
        .x_dp       (x_dp),
        .y_dp       (y_dp),
        .colour_dp  (colour_dp),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- downstream datapath model ----------------
    // Latches coordinates/colour on load (counter cleared), counts on enable.
    logic [7:0] dp_x;
    logic [7:0] dp_y;
    logic [2:0] dp_c;
    logic [5:0] dp_cnt;
    logic [7:0] x_out;
    logic [7:0] y_out;
    logic [2:0] colour_out;

    always @(posedge clock) begin
        if (load) begin
            dp_x   <= x_dp;
            dp_y   <= y_dp;
            dp_c   <= colour_dp;
            dp_cnt <= 6'd0;
        end else if (enable) begin
            dp_cnt <= dp_cnt + 6'd1;
        end
    end

    assign x_out      = dp_x + {5'd0, dp_cnt[2:0]};
    assign y_out      = dp_y + {5'd0, dp_cnt[5:3]};
    assign colour_out = flash ? 3'b111 : dp_c;

    // ---------------- vectors ----------------
    typedef struct {
        int x; int y; int col; int fl; int er; int intrude;
        int e_done; int e_loads; int e_plots;
        int e0x; int e0y; int e0c; int e0f;
        int e1x; int e1y; int e1c; int e1f;
        int e_fl_cnt;
        int fpx; int fpy; int lpx; int lpy;
        int pix;
    } vec_t;

    typedef struct {
        int done_cyc; int done_cnt; int loads; int plots;
        int l0x; int l0y; int l0c; int l0f;
        int l1x; int l1y; int l1c; int l1f;
        int fl_cnt;
        int fpx; int fpy; int lpx; int lpy;
        int bad_pix; int ready_early; int ready_after;
    } trace_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one request and record what the DUT does, cycle by cycle,
    // counting cycle 1 as the cycle after the accepting edge.
    task automatic run_req(input vec_t v, output trace_t t);
        bit first_plot;
        t = '{default: 0};
        first_plot = 1'b1;
        @(negedge clock);
        x_req      = 8'(v.x);
        y_req      = 8'(v.y);
        colour_req = 3'(v.col);
        flash_req  = v.fl[0];
        erase_en   = v.er[0];
        go         = 1'b1;
        step();
        go = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (v.intrude != 0 && c == 10) begin
                go    = 1'b1;
                x_req = 8'd99;
                y_req = 8'd99;
            end else if (v.intrude != 0 && c == 11) begin
                go = 1'b0;
            end
            if (t.done_cyc != 0 && c == t.done_cyc + 1) begin
                t.ready_after = int'(ready);
                break;
            end
            if (load) begin
                if (t.loads == 0) begin
                    t.l0x = int'(x_dp); t.l0y = int'(y_dp);
                    t.l0c = int'(colour_dp); t.l0f = int'(flash);
                end
                t.l1x = int'(x_dp); t.l1y = int'(y_dp);
                t.l1c = int'(colour_dp); t.l1f = int'(flash);
                t.loads++;
                t.bad_pix  = 0;
                first_plot = 1'b1;
            end
            if (plot) begin
                t.plots++;
                if (first_plot) begin
                    t.fpx = int'(x_out); t.fpy = int'(y_out);
                    first_plot = 1'b0;
                end
                t.lpx = int'(x_out); t.lpy = int'(y_out);
                if (int'(colour_out) != v.pix) t.bad_pix++;
            end
            if (flash) t.fl_cnt++;
            if (ready && t.done_cyc == 0) t.ready_early++;
            if (done) begin
                t.done_cnt++;
                if (t.done_cyc == 0) t.done_cyc = c;
            end
            step();
        end
    endtask

    task automatic check_vec(input int i, input vec_t v, input trace_t t);
        string p;
        p = $sformatf("v%0d_", i);
        chk({p, "done_cycle"}, t.done_cyc, v.e_done);
        chk({p, "done_count"}, t.done_cnt, 1);
        chk({p, "ready_busy"}, t.ready_early, 0);
        chk({p, "ready_back"}, t.ready_after, 1);
        chk({p, "loads"}, t.loads, v.e_loads);
        chk({p, "plots"}, t.plots, v.e_plots);
        chk({p, "load0_x"}, t.l0x, v.e0x);
        chk({p, "load0_y"}, t.l0y, v.e0y);
        chk({p, "load0_col"}, t.l0c, v.e0c);
        chk({p, "load0_flash"}, t.l0f, v.e0f);
        chk({p, "load1_x"}, t.l1x, v.e1x);
        chk({p, "load1_y"}, t.l1y, v.e1y);
        chk({p, "load1_col"}, t.l1c, v.e1c);
        chk({p, "load1_flash"}, t.l1f, v.e1f);
        chk({p, "flash_cycles"}, t.fl_cnt, v.e_fl_cnt);
        chk({p, "first_px_x"}, t.fpx, v.fpx);
        chk({p, "first_px_y"}, t.fpy, v.fpy);
        chk({p, "last_px_x"}, t.lpx, v.lpx);
        chk({p, "last_px_y"}, t.lpy, v.lpy);
        chk({p, "pixel_colour_errs"}, t.bad_pix, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        trace_t t;
        int     dn;

        //         x   y  col fl er in  done ld plots  ld0 x/y/c/f     ld1 x/y/c/f    flc  first  last   pix
        vecs[0] = '{10, 20, 4, 0, 0, 0,  66, 1,  64,   10, 20, 4, 0,   10, 20, 4, 0,   0, 10, 20, 17, 27, 4};
        vecs[1] = '{30,  5, 2, 0, 1, 0, 131, 2, 128,   10, 20, 0, 0,   30,  5, 2, 0,   0, 30,  5, 37, 12, 2};
        vecs[2] = '{40, 40, 1, 1, 0, 0,  66, 1,  64,   40, 40, 1, 1,   40, 40, 1, 1,  65, 40, 40, 47, 47, 7};
        vecs[3] = '{50, 60, 6, 0, 0, 1,  66, 1,  64,   50, 60, 6, 0,   50, 60, 6, 0,   0, 50, 60, 57, 67, 6};
        vecs[4] = '{70, 80, 5, 0, 1, 0,  66, 1,  64,   70, 80, 5, 0,   70, 80, 5, 0,   0, 70, 80, 77, 87, 5};
        vecs[5] = '{252, 0, 3, 0, 0, 0,  66, 1,  64,  252,  0, 3, 0,  252,  0, 3, 0,   0, 252, 0,  3,  7, 3};

        // reset block
        go = 1'b0; x_req = '0; y_req = '0; colour_req = '0;
        flash_req = 1'b0; erase_en = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
        chk("rst_load", int'(load), 0);
        chk("rst_enable", int'(enable), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_flash", int'(flash), 0);
        chk("rst_x_dp", int'(x_dp), 0);
        chk("rst_y_dp", int'(y_dp), 0);
        chk("rst_colour_dp", int'(colour_dp), 0);
        @(negedge clock);
        resetn = 1'b1;
        step();

        // first draw (erase_en=0), erase of it, flash, ignored go during DRAW
        for (int i = 0; i < 4; i++) begin
            run_req(vecs[i], t);
            check_vec(i, vecs[i], t);
        end

        // reset while drawing pixel 30
        @(negedge clock);
        x_req = 8'd90; y_req = 8'd90; colour_req = 3'd2;
        flash_req = 1'b0; erase_en = 1'b0; go = 1'b1;
        step();
        go = 1'b0;
        repeat (31) step();            // now in cycle 32: DRAW, pixel 30
        chk("mid_plot_before_rst", int'(plot), 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_plot", int'(plot), 0);
        chk("mid_rst_enable", int'(enable), 0);
        chk("mid_rst_load", int'(load), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_ready", int'(ready), 1);
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        dn = 0;
        for (int c = 0; c < 70; c++) begin
            step();
            if (done) dn++;
        end
        chk("mid_rst_no_done", dn, 0);

        // erase requested straight after reset is skipped; then x near 255
        for (int i = 4; i < 6; i++) begin
            run_req(vecs[i], t);
            check_vec(i, vecs[i], t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global time limit
    initial begin
        #500000;
        $display("FAIL timeout actual=%0d required=%0d", 1, 0);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
